// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the ibus/dbus to cbus arbiter.
// Bus bundles, FSM state, grant id and the latched request.
package mem_bus_arbiter_pkg;

  localparam logic [2:0] MSIZE1 = 3'b000;
  localparam logic [2:0] MSIZE2 = 3'b001;
  localparam logic [2:0] MSIZE4 = 3'b010;
  localparam logic [2:0] MSIZE8 = 3'b011;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [2:0]  size;
    logic [63:0] addr;
    logic [7:0]  strobe;
    logic [63:0] data;
    logic [7:0]  len;
    logic [1:0]  burst;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY_I = 2'd1,
    ST_BUSY_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_t;

  typedef struct packed {
    logic        is_write;
    logic [2:0]  size;
    logic [63:0] addr;
    logic [7:0]  strobe;
    logic [63:0] data;
  } saved_req_t;

  function automatic saved_req_t save_ireq(input ibus_req_t r);
    saved_req_t s;
    s.is_write = 1'b0;
    s.size     = MSIZE4;
    s.addr     = r.addr;
    s.strobe   = '0;
    s.data     = '0;
    return s;
  endfunction

  function automatic saved_req_t save_dreq(input dbus_req_t r);
    saved_req_t s;
    s.is_write = |r.strobe;
    s.size     = r.size;
    s.addr     = r.addr;
    s.strobe   = r.strobe;
    s.data     = r.data;
    return s;
  endfunction

endpackage

// File: rtl/arb_pick.sv
// Combinational grant choice between instruction and data requesters.
// ROUND_ROBIN=0 favours data; 1 alternates on contention.
module arb_pick
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ROUND_ROBIN = 0
) (
  input  logic   ivalid,
  input  logic   dvalid,
  input  grant_t last_grant,
  output logic   any,
  output grant_t grant
);

  grant_t rr_pick;

  assign rr_pick = (last_grant == GRANT_D) ? GRANT_I : GRANT_D;

  always_comb begin
    any   = ivalid | dvalid;
    grant = GRANT_D;
    unique case (1'b1)
      (ivalid && dvalid):
        grant = (ROUND_ROBIN != 0) ? rr_pick : GRANT_D;
      (ivalid && !dvalid):
        grant = GRANT_I;
      default:
        grant = GRANT_D;
    endcase
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares cbus between ibus and dbus, one single-beat txn at a time.
// Optional counters: define ARB_STATS_EN for stat_* outputs.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ROUND_ROBIN = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  ibus_req_t  ireq,
  output ibus_resp_t iresp,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp,
  output cbus_req_t  creq,
  input  cbus_resp_t cresp
`ifdef ARB_STATS_EN
  ,
  output logic [63:0] stat_igrant,
  output logic [63:0] stat_dgrant,
  output logic [63:0] stat_conflict
`endif
);

  arb_state_t state;
  grant_t     last_grant;
  saved_req_t saved;

  logic   pick_any;
  grant_t pick;
  logic   done;
  logic   busy_i;
  logic   busy_d;
  logic   idle;

  arb_pick #(
    .ROUND_ROBIN(ROUND_ROBIN)
  ) u_pick (
    .ivalid    (ireq.valid),
    .dvalid    (dreq.valid),
    .last_grant(last_grant),
    .any       (pick_any),
    .grant     (pick)
  );

  assign done   = cresp.ready & cresp.last;
  assign idle   = (state == ST_IDLE);
  assign busy_i = (state == ST_BUSY_I);
  assign busy_d = (state == ST_BUSY_D);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      last_grant <= GRANT_I;
      saved      <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (pick_any) begin
            last_grant <= pick;
            if (pick == GRANT_D) begin
              saved <= save_dreq(dreq);
              state <= ST_BUSY_D;
            end else begin
              saved <= save_ireq(ireq);
              state <= ST_BUSY_I;
            end
          end
        end
        ST_BUSY_I, ST_BUSY_D: begin
          if (done) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // cbus is fed purely from the latched request.
  always_comb begin
    creq          = '0;
    creq.valid    = !idle;
    creq.is_write = saved.is_write;
    creq.size     = saved.size;
    creq.addr     = saved.addr;
    creq.strobe   = saved.strobe;
    creq.data     = saved.data;
    creq.len      = 8'd0;
    creq.burst    = AXI_BURST_FIXED;
  end

  always_comb begin
    iresp         = '0;
    iresp.addr_ok = busy_i & done;
    iresp.data_ok = busy_i & done;
    if (busy_i)
      iresp.data = saved.addr[2] ? cresp.data[63:32]
                                 : cresp.data[31:0];
  end

  always_comb begin
    dresp         = '0;
    dresp.addr_ok = busy_d & done;
    dresp.data_ok = busy_d & done;
    if (busy_d)
      dresp.data = cresp.data;
  end

`ifdef ARB_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_igrant   <= '0;
      stat_dgrant   <= '0;
      stat_conflict <= '0;
    end else begin
      if (idle && pick_any && pick == GRANT_I)
        stat_igrant <= stat_igrant + 64'd1;
      if (idle && pick_any && pick == GRANT_D)
        stat_dgrant <= stat_dgrant + 64'd1;
      if (idle && ireq.valid && dreq.valid)
        stat_conflict <= stat_conflict + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: fixed-priority and round-robin
// instances side by side against a transaction-level model.
module tb_mem_bus_arbiter;
  import mem_bus_arbiter_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  ibus_req_t  ireq;
  dbus_req_t  dreq;
  cbus_resp_t cresp;
  ibus_resp_t iresp [2];
  dbus_resp_t dresp [2];
  cbus_req_t  creq  [2];

  int total = 0;
  int bad   = 0;

`ifdef ARB_STATS_EN
  logic [63:0] sig [2];
  logic [63:0] sdg [2];
  logic [63:0] scf [2];
`endif

  mem_bus_arbiter #(.ROUND_ROBIN(0)) dut0 (
    .clk  (clk),
    .reset(reset),
    .ireq (ireq),
    .iresp(iresp[0]),
    .dreq (dreq),
    .dresp(dresp[0]),
    .creq (creq[0]),
    .cresp(cresp)
`ifdef ARB_STATS_EN
    ,
    .stat_igrant  (sig[0]),
    .stat_dgrant  (sdg[0]),
    .stat_conflict(scf[0])
`endif
  );

  mem_bus_arbiter #(.ROUND_ROBIN(1)) dut1 (
    .clk  (clk),
    .reset(reset),
    .ireq (ireq),
    .iresp(iresp[1]),
    .dreq (dreq),
    .dresp(dresp[1]),
    .creq (creq[1]),
    .cresp(cresp)
`ifdef ARB_STATS_EN
    ,
    .stat_igrant  (sig[1]),
    .stat_dgrant  (sdg[1]),
    .stat_conflict(scf[1])
`endif
  );

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: who owns the bus and what it asked for.
  bit        m_busy [2];
  bit        m_isd  [2];
  bit        m_prevd[2];
  cbus_req_t m_req  [2];
  bit        glog   [2][$];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        m_busy[i]  = 0;
        m_prevd[i] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (m_busy[i]) begin
          if (cresp.ready && cresp.last) m_busy[i] = 0;
        end else if (ireq.valid || dreq.valid) begin
          if (ireq.valid && dreq.valid)
            m_isd[i] = (i == 0) ? 1'b1 : !m_prevd[i];
          else
            m_isd[i] = dreq.valid;
          m_busy[i]  = 1;
          m_prevd[i] = m_isd[i];
          glog[i].push_back(m_isd[i]);
          m_req[i]       = '0;
          m_req[i].valid = 1'b1;
          m_req[i].burst = 2'b00;
          if (m_isd[i]) begin
            m_req[i].is_write = |dreq.strobe;
            m_req[i].size     = dreq.size;
            m_req[i].addr     = dreq.addr;
            m_req[i].strobe   = dreq.strobe;
            m_req[i].data     = dreq.data;
          end else begin
            m_req[i].size = 3'd2;
            m_req[i].addr = ireq.addr;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk("creq_valid", creq[i].valid, reset && m_busy[i]);
      if (reset && m_busy[i]) begin
        chk("creq_addr", creq[i].addr, m_req[i].addr);
        chk("creq_wr", creq[i].is_write, m_req[i].is_write);
        chk("creq_size", creq[i].size, m_req[i].size);
        chk("creq_strb", creq[i].strobe, m_req[i].strobe);
        chk("creq_data", creq[i].data, m_req[i].data);
        chk("creq_len", creq[i].len, 0);
        chk("creq_burst", creq[i].burst, 0);
      end
      chk("i_ok", {iresp[i].addr_ok, iresp[i].data_ok},
          {2{reset && m_busy[i] && !m_isd[i] &&
             cresp.ready && cresp.last}});
      chk("d_ok", {dresp[i].addr_ok, dresp[i].data_ok},
          {2{reset && m_busy[i] && m_isd[i] &&
             cresp.ready && cresp.last}});
      if (iresp[i].data_ok)
        chk("i_data", iresp[i].data,
            m_req[i].addr[2] ? cresp.data[63:32] : cresp.data[31:0]);
      if (dresp[i].data_ok)
        chk("d_data", dresp[i].data, cresp.data);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic finish_txn(input logic [63:0] d);
    int n = 0;
    while (!creq[0].valid && n < 20) begin
      step();
      n++;
    end
    chk("busy_wait", creq[0].valid, 1'b1);
    cresp.ready = 1'b1;
    cresp.last  = 1'b1;
    cresp.data  = d;
    step();
    cresp = '0;
  endtask

  initial begin
    ireq  = '0;
    dreq  = '0;
    cresp = '0;
    ireq.valid = 1'b1;
    ireq.addr  = 64'h40;
    repeat (2) step();
    chk("rst_cvalid", creq[0].valid, 1'b0);
    chk("rst_iok", iresp[0].data_ok, 1'b0);
    chk("rst_dok", dresp[0].data_ok, 1'b0);
    reset = 1'b1;
    step();
    chk("rel_cvalid", creq[0].valid, 1'b1);
    chk("rel_addr", creq[0].addr, 64'h40);
    chk("rel_size", creq[0].size, 3'd2);
    chk("rel_wr", creq[0].is_write, 1'b0);
    ireq.valid = 1'b0;
    finish_txn(64'h5);
    step();

    // isolated fetch, upper word
    ireq.valid = 1'b1;
    ireq.addr  = 64'h8000_0004;
    step();
    ireq.valid = 1'b0;
    cresp.ready = 1'b1;
    cresp.last  = 1'b1;
    cresp.data  = 64'h1111_2222_3333_4444;
    #1;
    chk("if_data", iresp[0].data, 32'h1111_2222);
    chk("if_ok", iresp[0].data_ok, 1'b1);
    chk("if_dok", dresp[0].data_ok, 1'b0);
    @(posedge clk);
    #1;
    cresp = '0;
    #1;
    chk("if_ok_drop", iresp[0].data_ok, 1'b0);
    step();

    // isolated store
    dreq.valid  = 1'b1;
    dreq.addr   = 64'h100;
    dreq.size   = 3'd3;
    dreq.strobe = 8'h0F;
    dreq.data   = 64'hAB;
    step();
    dreq.valid = 1'b0;
    dreq.data  = 64'hCD;
    chk("st_wr", creq[0].is_write, 1'b1);
    chk("st_strb", creq[0].strobe, 8'h0F);
    chk("st_data", creq[0].data, 64'hAB);
    cresp.ready = 1'b1;
    cresp.last  = 1'b1;
    cresp.data  = 64'h77;
    #1;
    chk("st_ok", dresp[0].data_ok, 1'b1);
    @(posedge clk);
    #1;
    cresp = '0;
    step();

    // request changes while busy; ready without last
    ireq.valid = 1'b1;
    ireq.addr  = 64'h200;
    step();
    ireq.addr = 64'h300;
    step();
    chk("hold_addr", creq[0].addr, 64'h200);
    cresp.ready = 1'b1;
    cresp.data  = 64'h99;
    #1;
    chk("nolast_ok", iresp[0].data_ok, 1'b0);
    @(posedge clk);
    #1;
    cresp = '0;
    chk("nolast_busy", creq[0].valid, 1'b1);
    ireq.valid = 1'b0;
    finish_txn(64'h1234_5678_9ABC_DEF0);
    step();

    // contention: fixed priority vs alternation
    glog[0].delete();
    glog[1].delete();
    ireq.valid  = 1'b1;
    ireq.addr   = 64'h400;
    dreq.valid  = 1'b1;
    dreq.addr   = 64'h800;
    dreq.size   = 3'd3;
    dreq.strobe = 8'h00;
    dreq.data   = 64'h0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("c_size0", creq[0].size, 3'd3);
      chk("c_size1", creq[1].size, (k % 2 == 0) ? 3'd3 : 3'd2);
      finish_txn(64'(k));
    end
    ireq.valid = 1'b0;
    dreq.valid = 1'b0;
    chk("m_len0", glog[0].size(), 4);
    chk("m_len1", glog[1].size(), 4);
    if (glog[1].size() == 4) begin
      chk("m_rr0", glog[1][0], 1'b1);
      chk("m_rr1", glog[1][1], 1'b0);
      chk("m_rr2", glog[1][2], 1'b1);
      chk("m_rr3", glog[1][3], 1'b0);
    end
    if (glog[0].size() == 4)
      chk("m_fp", glog[0][3], 1'b1);
    step();

    // async reset in the middle of a data txn
    dreq.valid  = 1'b1;
    dreq.addr   = 64'h900;
    dreq.strobe = 8'hFF;
    step();
    dreq.valid = 1'b0;
    chk("ar_busy", creq[0].valid, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    chk("ar_drop0", creq[0].valid, 1'b0);
    chk("ar_drop1", creq[1].valid, 1'b0);
    chk("ar_dok", dresp[0].data_ok, 1'b0);
    ireq.valid = 1'b1;
    dreq.valid = 1'b1;
    step();
    reset = 1'b1;
    step();
    chk("ar_pick0", creq[0].size, 3'd3);
    chk("ar_pick1", creq[1].size, 3'd3);
    ireq.valid = 1'b0;
    dreq.valid = 1'b0;
    finish_txn(64'hFEED);
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
